// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory block: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/bram_be.sv
// Single-port word memory with per-byte write enables and a registered read.
// One address is shared by read and write; a write cycle also returns the
// pre-write word on rdata (read-before-write). Contents are never cleared.
module bram_be #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes and synchronous read, both only when enabled
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit in front of a byte-enabled word memory. One request in
// flight; illegal accesses answer after one cycle without touching memory,
// legal ones after two. Lane selection and load extension live here.
//
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | memory read or byte-lane write in progress
//   RESP   | response held until rsp_ready
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int IW = $clog2(DEPTH);

  lsu_state_t state, state_nxt;

  logic          accept;
  logic          req_err;
  logic [AW-1:0] word_idx;

  logic          r_write;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [1:0]    r_lane;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [3:0]    lane_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   lane_data;
  logic [31:0]   load_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Request legality: bad size, misalignment, or word index beyond the array
  always_comb begin
    word_idx = req_addr >> 2;
    req_err  = (req_size == 2'b11)
            || ((req_size == SZ_H) && req_addr[0])
            || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
            || (word_idx >= AW'(DEPTH));
  end

  // Capture the request fields at the accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_size     <= SZ_W;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else if (accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_lane     <= req_addr[1:0];
      r_idx      <= req_addr[IW+1:2];
      r_wdata    <= req_wdata;
      r_err      <= req_err;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: errors skip the memory access entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_err ? RESP : ACCESS;
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store lane enables and data replicated across lanes
  always_comb begin
    lane_be   = 4'b1111;
    mem_wdata = r_wdata;
    case (r_size)
      SZ_B: begin
        lane_be   = 4'b0001 << r_lane;
        mem_wdata = {4{r_wdata[7:0]}};
      end
      SZ_H: begin
        lane_be   = r_lane[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        mem_wdata = r_wdata;
      end
    endcase
  end

  // Memory only runs in ACCESS; a write coinciding with reset is dropped
  always_comb begin
    mem_en = (state == ACCESS) && !reset;
    mem_we = (r_write && mem_en) ? lane_be : 4'b0000;
  end

  bram_be #(.DEPTH(DEPTH)) u_bram (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (r_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Lane select and extension; the read register holds through RESP
  always_comb begin
    lane_data = 16'(mem_rdata >> {r_lane, 3'b000});
    case (r_size)
      SZ_B:    load_data = r_unsigned ? {24'h0, lane_data[7:0]}
                                      : {{24{lane_data[7]}}, lane_data[7:0]};
      SZ_H:    load_data = r_unsigned ? {16'h0, lane_data}
                                      : {{16{lane_data[15]}}, lane_data};
      default: load_data = mem_rdata;
    endcase
  end

  // Response outputs are derived from state so they are stable in RESP
  always_comb begin
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && r_err;
    rsp_rdata = ((state == RESP) && !r_err && !r_write) ? load_data : 32'h0;
  end

endmodule
